// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle adder/subtractor. It processes DIGIT bits per
// clock through a single ripple slice and keeps the carry in a flop between
// cycles. An operation takes N = WIDTH/DIGIT processing edges, and then a
// one-cycle done pulse is raised.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one DIGIT-wide slice is processed per edge
// DONE  | result registers have just updated; done pulse; start accepted here too
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   slice_full;
    logic             slice_cin_msb;
    logic [WIDTH-1:0] res_next;

    // One ripple slice over the low DIGIT bits, plus the result shifted in from the top
    always_comb begin
        slice_full    = {1'b0, areg[DIGIT-1:0]} + {1'b0, breg[DIGIT-1:0]}
                        + {{DIGIT{1'b0}}, carry};
        // Carry into the slice MSB can be recovered from the sum bit and the operand bits
        slice_cin_msb = slice_full[DIGIT-1] ^ areg[DIGIT-1] ^ breg[DIGIT-1];
        res_next      = (res >> DIGIT)
                        | (WIDTH'(slice_full[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    // Control FSM with the datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            areg  <= '0;
            breg  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        areg  <= a;
                        breg  <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    areg  <= areg >> DIGIT;
                    breg  <= breg >> DIGIT;
                    res   <= res_next;
                    carry <= slice_full[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        sum   <= res_next;
                        cout  <= slice_full[DIGIT];
                        ovf   <= slice_cin_msb ^ slice_full[DIGIT];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub. It uses five instances that cover different
// width/digit combinations:
// 0:(8,1) 1:(8,4) 2:(4,1) 3:(4,2) 4:(4,4).
module tb_serial_add_sub;

    logic       clk;
    logic       rst;
    logic [7:0] da;
    logic [7:0] db;
    logic       dcin;
    logic       dsub;
    logic       start_w [0:4];
    logic       busy_w  [0:4];
    logic       done_w  [0:4];
    logic       cout_w  [0:4];
    logic       ovf_w   [0:4];
    logic [7:0] sum_w   [0:4];
    logic [3:0] s4      [2:4];

    int errors = 0;
    int checks = 0;

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst(rst), .start(start_w[0]),
        .a(da), .b(db), .cin(dcin), .sub(dsub), .busy(busy_w[0]), .done(done_w[0]),
        .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]));
    serial_add_sub #(.WIDTH(8), .DIGIT(4)) u1 (.clk(clk), .rst(rst), .start(start_w[1]),
        .a(da), .b(db), .cin(dcin), .sub(dsub), .busy(busy_w[1]), .done(done_w[1]),
        .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));
    serial_add_sub #(.WIDTH(4), .DIGIT(1)) u2 (.clk(clk), .rst(rst), .start(start_w[2]),
        .a(da[3:0]), .b(db[3:0]), .cin(dcin), .sub(dsub), .busy(busy_w[2]), .done(done_w[2]),
        .sum(s4[2]), .cout(cout_w[2]), .ovf(ovf_w[2]));
    serial_add_sub #(.WIDTH(4), .DIGIT(2)) u3 (.clk(clk), .rst(rst), .start(start_w[3]),
        .a(da[3:0]), .b(db[3:0]), .cin(dcin), .sub(dsub), .busy(busy_w[3]), .done(done_w[3]),
        .sum(s4[3]), .cout(cout_w[3]), .ovf(ovf_w[3]));
    serial_add_sub #(.WIDTH(4), .DIGIT(4)) u4 (.clk(clk), .rst(rst), .start(start_w[4]),
        .a(da[3:0]), .b(db[3:0]), .cin(dcin), .sub(dsub), .busy(busy_w[4]), .done(done_w[4]),
        .sum(s4[4]), .cout(cout_w[4]), .ovf(ovf_w[4]));

    assign sum_w[2] = {4'b0, s4[2]};
    assign sum_w[3] = {4'b0, s4[3]};
    assign sum_w[4] = {4'b0, s4[4]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         k;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] esum;
        logic       ecout;
        logic       eovf;
    } vec_t;

    vec_t vecs [0:7];

    function automatic int lat_of(input int k);
        case (k)
            0: return 8;
            1: return 2;
            2: return 4;
            3: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int width_of(input int k);
        return (k < 2) ? 8 : 4;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: integer arithmetic, with overflow taken from operand and result signs
    task automatic model(input int w, input int a, input int b, input bit cin, input bit sub,
                         output int esum, output bit ecout, output bit eovf);
        int mask;
        int bb;
        int r;
        mask  = (1 << w) - 1;
        bb    = sub ? (~b & mask) : b;
        r     = a + bb + (sub ? int'(!cin) : int'(cin));
        esum  = r & mask;
        ecout = r[w];
        eovf  = (a[w-1] == bb[w-1]) && (esum[w-1] != a[w-1]);
    endtask

    task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub, input int esum,
                          input bit ecout, input bit eovf, input string name);
        int n;
        int busy_bad;
        @(negedge clk);
        da = a; db = b; dcin = cin; dsub = sub;
        start_w[k] = 1'b1;
        @(posedge clk); #1;
        start_w[k] = 1'b0;
        check({name, " busy_after_accept"}, int'(busy_w[k]), 1);
        n = 0;
        busy_bad = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done_w[k]) break;
            if (!busy_w[k]) busy_bad++;
        end
        check({name, " latency"}, n, lat_of(k));
        check({name, " busy_during_run"}, busy_bad, 0);
        check({name, " sum"}, int'(sum_w[k]), esum);
        check({name, " cout"}, int'(cout_w[k]), int'(ecout));
        check({name, " ovf"}, int'(ovf_w[k]), int'(eovf));
        check({name, " busy_at_done"}, int'(busy_w[k]), 0);
    endtask

    initial begin
        int   n;
        int   es;
        bit   ec;
        bit   eo;
        int   seen;
        rst = 1'b1;
        da = '0; db = '0; dcin = 1'b0; dsub = 1'b0;
        for (int i = 0; i < 5; i++) start_w[i] = 1'b0;

        vecs[0] = '{0, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{1, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{1, 8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{0, 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};
        vecs[7] = '{1, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};

        #12;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("reset busy%0d", k), int'(busy_w[k]), 0);
            check($sformatf("reset done%0d", k), int'(done_w[k]), 0);
            check($sformatf("reset sum%0d", k), int'(sum_w[k]), 0);
            check($sformatf("reset flags%0d", k), int'({cout_w[k], ovf_w[k]}), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   int'(vecs[i].esum), vecs[i].ecout, vecs[i].eovf, $sformatf("vec%0d", i));

        // Done is a single-cycle pulse and the instance returns to idle
        @(posedge clk); #1;
        check("done_pulse_width", int'(done_w[1]), 0);
        check("idle_busy", int'(busy_w[1]), 0);
        check("result_held", int'(sum_w[1]), 8'hFF);

        // Handshake: start held, operands change during RUN, then a back-to-back op
        @(negedge clk);
        da = 8'h12; db = 8'h34; dcin = 1'b0; dsub = 1'b0;
        start_w[0] = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (n < 20) begin
            da = da + 8'h11; db = db ^ 8'hA5; dcin = ~dcin; dsub = ~dsub;
            @(posedge clk); #1;
            n++;
            if (done_w[0]) break;
        end
        check("hs first latency", n, 8);
        check("hs first sum", int'(sum_w[0]), 8'h46);
        check("hs first flags", int'({cout_w[0], ovf_w[0]}), 0);
        da = 8'h01; db = 8'h02; dcin = 1'b0; dsub = 1'b0;
        @(posedge clk); #1;
        start_w[0] = 1'b0;
        da = 8'hEE; db = 8'hEE; dcin = 1'b1; dsub = 1'b1;
        check("hs reaccept busy", int'(busy_w[0]), 1);
        check("hs sum held mid-run", int'(sum_w[0]), 8'h46);
        n = 1;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done_w[0]) break;
        end
        check("hs second done spacing", n, 9);
        check("hs second sum", int'(sum_w[0]), 8'h03);

        // Reset asserted asynchronously during the third RUN cycle
        @(negedge clk);
        da = 8'h33; db = 8'h11; dcin = 1'b0; dsub = 1'b0;
        start_w[0] = 1'b1;
        @(posedge clk); #1;
        start_w[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst busy", int'(busy_w[0]), 0);
        check("rst done", int'(done_w[0]), 0);
        check("rst sum", int'(sum_w[0]), 0);
        check("rst flags", int'({cout_w[0], ovf_w[0]}), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_w[0] || busy_w[0]) seen++;
        end
        check("rst no done after abort", seen, 0);
        run_op(0, 8'h33, 8'h11, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, "post_rst");

        // Exhaustive 4-bit sweep on all three digit sizes
        for (int k = 2; k < 5; k++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    for (int c = 0; c < 2; c++)
                        for (int s = 0; s < 2; s++) begin
                            model(width_of(k), a, b, c[0], s[0], es, ec, eo);
                            run_op(k, 8'(a), 8'(b), c[0], s[0], es, ec, eo,
                                   $sformatf("ex k%0d a%0d b%0d c%0d s%0d", k, a, b, c, s));
                        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
